// File: rtl/regbank_ctrl.sv
// Two-requester register-bank access controller: round-robin arbitration in
// IDLE, then a single write (WR) or read (RD, CAP) on a shared tri-state bus.
module regbank_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  bank_cs,
  output logic                  bank_rd_wr,
  output logic [ADDR_WIDTH-1:0] bank_addr,
  inout  wire  [DATA_WIDTH-1:0] bank_data,
  output logic [2:0]            state_dbg
);

  // Handshake: a requester raises req with we/addr/wdata and holds them until
  // its one-cycle ack; req is sampled only in IDLE, so a req still high in the
  // IDLE after ack is a fresh request and changes elsewhere are ignored.

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    CAP  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic                    gnt_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [DATA_WIDTH-1:0]   wdata_r;

  logic                    any_req;
  logic                    grant_sel;
  logic                    sel_we;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic                    drive_en;

  // gnt_r doubles as the last-served requester; resetting it to 1 hands
  // priority to requester 0.
  always_comb begin
    any_req   = req0 | req1;
    grant_sel = (req0 && req1) ? ~gnt_r : req1;
    sel_we    = grant_sel ? we1    : we0;
    sel_addr  = grant_sel ? addr1  : addr0;
    sel_wdata = grant_sel ? wdata1 : wdata0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = sel_we ? WR : RD;
      WR:      state_nxt = DONE;
      RD:      state_nxt = CAP;
      CAP:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bank_cs    = 1'b0;
    bank_rd_wr = 1'b1;
    drive_en   = 1'b0;
    ack0       = 1'b0;
    ack1       = 1'b0;
    case (state)
      WR: begin
        bank_cs    = 1'b1;
        bank_rd_wr = 1'b0;
        drive_en   = 1'b1;
      end
      RD, CAP: bank_cs = 1'b1;
      DONE: begin
        ack0 = ~gnt_r;
        ack1 = gnt_r;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_r   <= 1'b1;
      addr_r  <= '0;
      wdata_r <= '0;
    end else if (state == IDLE && any_req) begin
      gnt_r   <= grant_sel;
      addr_r  <= sel_addr;
      wdata_r <= sel_wdata;
    end
  end

  // The bank drives the bus throughout RD and CAP; sampling at the end of CAP
  // gives it a full cycle to settle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (state == CAP) begin
      rdata <= bank_data;
    end
  end

  assign bank_data = drive_en ? wdata_r : {DATA_WIDTH{1'bz}};
  assign bank_addr = addr_r;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_regbank_ctrl.sv
// Bench for regbank_ctrl: behavioural register bank on the tri-state bus,
// transaction-level reference model (memory array, round-robin last-served).
module tb_regbank_ctrl;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam logic [DW-1:0] INIT_MEM [0:7] = '{8'h12, 8'h34, 8'h56, 8'h78,
                                               8'h9A, 8'hBC, 8'hDE, 8'h21};

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, busy, bank_cs, bank_rd_wr;
  logic [DW-1:0] rdata;
  logic [AW-1:0] bank_addr;
  logic [2:0]    state_dbg;
  wire  [DW-1:0] bank_data;

  regbank_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .bank_cs(bank_cs), .bank_rd_wr(bank_rd_wr), .bank_addr(bank_addr),
    .bank_data(bank_data), .state_dbg(state_dbg)
  );

  // Released bus reads all-ones; stimulus never writes 8'hFF.
  pullup (bank_data);

  logic [DW-1:0] bank_mem [0:7] = INIT_MEM;
  assign bank_data = (bank_cs && bank_rd_wr) ? bank_mem[bank_addr] : {DW{1'bz}};
  always @(posedge clk) begin
    if (bank_cs && !bank_rd_wr) bank_mem[bank_addr] <= bank_data;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int bus_errs = 0;

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (bank_cs === 1'b1 && $isunknown(bank_data)) begin
        bus_errs++;
        $display("FAIL bus_x: got %h required known data at %0t", bank_data, $time);
      end else if (bank_cs !== 1'b1 && bank_data !== 8'hFF) begin
        bus_errs++;
        $display("FAIL bus_release: got %h required released (FF) at %0t", bank_data, $time);
      end
    end
  end

  // reference model state
  logic [DW-1:0] ref_mem [0:7];
  logic [DW-1:0] ref_rdata;
  logic          ref_last;
  logic          op_we   [2];
  logic [AW-1:0] op_addr [2];
  logic [DW-1:0] op_wd   [2];

  task automatic check_reset_outputs(input string name);
    n_tests++;
    if ({bank_cs, bank_rd_wr, bank_addr, ack0, ack1, rdata, busy} !==
        {1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL %s outputs: got cs=%b rw=%b addr=%0d ack=%b%b rdata=%h busy=%b required 0,1,0,00,00,0",
               name, bank_cs, bank_rd_wr, bank_addr, ack1, ack0, rdata, busy);
    end
    n_tests++;
    if (bank_data !== 8'hFF) begin
      n_fail++;
      $display("FAIL %s bank_data: got %h required released", name, bank_data);
    end
  endtask

  // One or two requests presented together in IDLE; each wanted port is served
  // once in round-robin order, dropping req the cycle after its ack.
  task automatic run_ops(input logic r0, input logic r1, input string name);
    logic want [2];
    int lat [2];
    int start [2];
    int ack_at [2];
    int first, last_cyc;
    logic exp_busy, exp_cs;
    logic exp_a [2];
    logic [DW-1:0] exp_val;
    want[0] = r0;
    want[1] = r1;
    lat[0] = op_we[0] ? 2 : 3;
    lat[1] = op_we[1] ? 2 : 3;
    if (r0 && r1) first = (ref_last == 1'b1) ? 0 : 1;
    else          first = r0 ? 0 : 1;
    start[first]      = 0;
    ack_at[first]     = lat[first];
    start[1-first]    = lat[first] + 1;
    ack_at[1-first]   = start[1-first] + lat[1-first];
    last_cyc = (r0 && r1) ? ack_at[1-first] : ack_at[first];

    @(posedge clk); #1;
    req0 = r0; we0 = op_we[0]; addr0 = op_addr[0]; wdata0 = op_wd[0];
    req1 = r1; we1 = op_we[1]; addr1 = op_addr[1]; wdata1 = op_wd[1];
    for (int cyc = 1; cyc <= last_cyc; cyc++) begin
      @(posedge clk); #1;
      if (want[0] && cyc == ack_at[0] + 1) req0 = 1'b0;
      if (want[1] && cyc == ack_at[1] + 1) req1 = 1'b0;
      @(negedge clk);
      exp_busy = 1'b0;
      exp_cs   = 1'b0;
      for (int p = 0; p < 2; p++) begin
        exp_a[p] = want[p] && (cyc == ack_at[p]);
        if (want[p] && cyc > start[p] && cyc <= ack_at[p]) begin
          exp_busy = 1'b1;
          if (cyc < ack_at[p]) exp_cs = 1'b1;
          n_tests++;
          if (bank_addr !== op_addr[p]) begin
            n_fail++;
            $display("FAIL %s bank_addr cyc%0d: got %0d required %0d", name, cyc, bank_addr, op_addr[p]);
          end
          n_tests++;
          if (op_we[p] && cyc == start[p] + 1) begin
            if (bank_rd_wr !== 1'b0 || bank_data !== op_wd[p]) begin
              n_fail++;
              $display("FAIL %s write_bus cyc%0d: got rw=%b data=%h required 0/%h",
                       name, cyc, bank_rd_wr, bank_data, op_wd[p]);
            end
          end else if (bank_rd_wr !== 1'b1) begin
            n_fail++;
            $display("FAIL %s rd_wr cyc%0d: got %b required 1", name, cyc, bank_rd_wr);
          end
        end
      end
      n_tests++;
      if (busy !== exp_busy || bank_cs !== exp_cs) begin
        n_fail++;
        $display("FAIL %s busy_cs cyc%0d: got %b%b required %b%b", name, cyc, busy, bank_cs, exp_busy, exp_cs);
      end
      n_tests++;
      if (ack0 !== exp_a[0] || ack1 !== exp_a[1]) begin
        n_fail++;
        $display("FAIL %s acks cyc%0d: got %b%b required %b%b", name, cyc, ack1, ack0, exp_a[1], exp_a[0]);
      end
      for (int p = 0; p < 2; p++) begin
        if (exp_a[p]) begin
          exp_val = op_we[p] ? ref_rdata : ref_mem[op_addr[p]];
          n_tests++;
          if (rdata !== exp_val) begin
            n_fail++;
            $display("FAIL %s rdata port%0d: got %h required %h", name, p, rdata, exp_val);
          end
          if (op_we[p]) ref_mem[op_addr[p]] = op_wd[p];
          else          ref_rdata = exp_val;
        end
      end
    end
    @(posedge clk); #1;
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle_after: got busy=%b required 0", name, busy);
    end
    ref_last = (r0 && r1) ? (first == 0) : (first == 1);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    for (int i = 0; i < 8; i++) ref_mem[i] = INIT_MEM[i];
    #1;
    check_reset_outputs("reset_t0");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_held");
    @(posedge clk); #1;
    reset = 1'b1;
    ref_rdata = '0;
    ref_last  = 1'b1;
  endtask

  task automatic test_write_read;
    op_we[0] = 1; op_addr[0] = 3'd5; op_wd[0] = 8'hA5;
    run_ops(1, 0, "wr_a5");
    op_we[0] = 0;
    run_ops(1, 0, "rd_a5");
    op_we[1] = 0; op_addr[1] = 3'd0; op_wd[1] = 8'h00;
    run_ops(0, 1, "rd_port1");
  endtask

  task automatic test_contention;
    int p;
    reset = 1'b0;
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 3'd1; addr1 = 3'd2;
    @(posedge clk); #1;
    reset = 1'b1;
    ref_rdata = '0;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      p = (cyc / 4) % 2;
      n_tests++;
      if (ack0 !== (cyc % 4 == 3 && p == 0) || ack1 !== (cyc % 4 == 3 && p == 1)) begin
        n_fail++;
        $display("FAIL contention acks cyc%0d: got %b%b required port%0d at cycles 3,7,11,15",
                 cyc, ack1, ack0, p);
      end
      if (cyc % 4 == 3) begin
        n_tests++;
        if (rdata !== ref_mem[p == 0 ? 1 : 2]) begin
          n_fail++;
          $display("FAIL contention rdata cyc%0d: got %h required %h", cyc, rdata, ref_mem[p == 0 ? 1 : 2]);
        end
      end
    end
    @(posedge clk); #1;
    req0 = 0;
    req1 = 0;
    ref_last  = 1'b1;
    ref_rdata = ref_mem[2];
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL contention idle: got busy=%b required 0", busy);
    end
  endtask

  task automatic test_bus_discipline;
    op_we[0] = 0; op_addr[0] = 3'd3; op_wd[0] = 8'h00;
    op_we[1] = 1; op_addr[1] = 3'd3; op_wd[1] = 8'h3C;
    run_ops(1, 1, "bus_rd_wr");
    op_we[0] = 0;
    run_ops(1, 0, "bus_readback");
  endtask

  task automatic test_reset_abort;
    op_we[0] = 1; op_addr[0] = 3'd6; op_wd[0] = 8'h11;
    run_ops(1, 0, "abort_pre");
    @(posedge clk); #1;
    req0 = 1; we0 = 1; addr0 = 3'd6; wdata0 = 8'h77;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (bank_cs !== 1'b1 || bank_rd_wr !== 1'b0 || bank_data !== 8'h77) begin
      n_fail++;
      $display("FAIL abort_in_wr: got cs=%b rw=%b data=%h required 1/0/77", bank_cs, bank_rd_wr, bank_data);
    end
    #1;
    reset = 1'b0;
    #1;
    check_reset_outputs("abort_reset");
    req0 = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (ack0 !== 1'b0 || ack1 !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_no_ack: got ack=%b%b busy=%b required 0", ack1, ack0, busy);
      end
    end
    @(posedge clk); #1;
    reset = 1'b1;
    ref_rdata = '0;
    ref_last  = 1'b1;
    op_we[0] = 0;
    run_ops(1, 0, "abort_readback");
  endtask

  task automatic test_random;
    logic r0, r1;
    for (int it = 0; it < 24; it++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) r1 = 1'b1;
      for (int p = 0; p < 2; p++) begin
        op_we[p]   = 1'($urandom_range(0, 1));
        op_addr[p] = 3'($urandom_range(0, 7));
        op_wd[p]   = 8'($urandom_range(0, 254));
      end
      run_ops(r0, r1, "random");
    end
  endtask

  task automatic test_idle;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b0 || bank_cs !== 1'b0 || bank_data !== 8'hFF) begin
        n_fail++;
        $display("FAIL idle cyc%0d: got busy=%b cs=%b data=%h required 0/0/released", i, busy, bank_cs, bank_data);
      end
    end
  endtask

  task automatic test_bus_checker;
    n_tests++;
    if (bus_errs !== 0) begin
      n_fail++;
      $display("FAIL bus_checker: got %0d bus errors required 0", bus_errs);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_contention();
    test_bus_discipline();
    test_reset_abort();
    test_random();
    test_idle();
    test_bus_checker();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regbank_ctrl.md
REGBANK_CTRL -- requirements
Module: regbank_ctrl

Interface
REQ-001 Parameters SHALL be:
  DATA_WIDTH  8  width of bank data bus and requester data
  ADDR_WIDTH  3  width of bank register address
REQ-002 Ports SHALL be:
  clk  in  1  single clock, all state on rising edge
  reset  in  1  asynchronous, active-low reset
  req0 / req1  in  1  requester access request
  we0 / we1  in  1  1=write, 0=read, valid with req
  addr0 / addr1  in  ADDR_WIDTH  target register
  wdata0 / wdata1  in  DATA_WIDTH  write data
  ack0 / ack1  out  1  one-cycle completion pulse
  rdata  out  DATA_WIDTH  read result, valid with ack of a read
  busy  out  1  high whenever state is not IDLE
  bank_cs  out  1  register bank chip select
  bank_rd_wr  out  1  1=read, 0=write
  bank_addr  out  ADDR_WIDTH  register bank address
  bank_data  inout  DATA_WIDTH  shared tri-state bank data bus
REQ-003 One clock; reset is asynchronous and active-low; ports are named clk and reset.

Function
REQ-004 The FSM SHALL have exactly five states: IDLE, WR, RD, CAP, DONE.
REQ-005 IDLE: if any req is high, grant one requester, latch its we/addr/wdata, and go to WR (we=1) or RD (we=0); otherwise stay in IDLE.
REQ-006 Arbitration SHALL be round-robin: the requester not served last has priority; with a single request, that request wins.
REQ-007 WR: bank_cs=1, bank_rd_wr=0, bank_addr=latched addr, bank_data driven with latched wdata; next state DONE.
REQ-008 RD: bank_cs=1, bank_rd_wr=1, bank_addr=latched addr, bank_data released (Z); next state CAP.
REQ-009 CAP: outputs as in RD; rdata SHALL capture bank_data on the rising edge that ends CAP; next state DONE.
REQ-010 DONE: bank_cs=0, bank_rd_wr=1, ack of the granted requester=1 for exactly this cycle, bank_data Z; next state IDLE.
REQ-011 bank_data SHALL be driven only in WR; in every other state and during reset it SHALL be Z, giving at least two non-driving cycles before any later WR.
REQ-012 Latency from the IDLE grant cycle: write ack at cycle +2, read ack at cycle +3; one access completes per 3 (write) or 4 (read) cycles.
REQ-013 rdata SHALL hold its value until the next read capture; writes SHALL NOT alter rdata.
REQ-014 The requester SHALL hold req and its operands stable until ack and drop req in the cycle after ack; req still high in IDLE after ack is treated as a new request.
REQ-015 Request changes on either port outside IDLE SHALL be ignored until the next IDLE.
REQ-016 Outside WR/RD/CAP, bank_cs SHALL be 0, bank_addr SHALL hold the last granted address, and at most one ack SHALL be high.
REQ-017 Simultaneous req0 and req1 in IDLE SHALL grant exactly one requester; the other is served in the next IDLE if still requesting.

Reset
REQ-018 On reset low, state SHALL go to IDLE immediately, with bank_cs=0, bank_rd_wr=1, bank_addr=0, bank_data Z, ack0=ack1=0, rdata=0, busy=0, and round-robin priority on requester 0.
REQ-019 Reset during WR/RD/CAP SHALL abort the access without ack; the aborted request is not retried.
REQ-020 After reset releases, the first rising edge with a req high SHALL perform a normal IDLE grant.

Verification
REQ-021 Write then read: req0 we0=1 addr0=5 wdata0=0xA5 -> ack0 at +2; then req0 we0=0 addr0=5 -> ack0 at +3 with rdata=0xA5.
REQ-022 Contention: req0 and req1 both held from reset release, reads of addr 1 and 2 -> grant order 0,1,0,1; acks never overlap.
REQ-023 Bus discipline: back-to-back read addr 3 then write addr 3 0x3C -> bank_data never driven by the controller while the bank drives; a checker flags X or contention.
REQ-024 Reset abort: reset asserted in WR of a write 0x77 to addr 6 -> no ack, outputs at reset values in the same cycle, and a later read of addr 6 returns the pre-reset value.
REQ-025 Idle: no req for 10 cycles -> busy=0, bank_cs=0, bank_data Z throughout.
